// File: rtl/ahb_lite_hrdata_read_buffer_pkg.sv
// Shared AHB-Lite encodings and constants used by the master interface and
// its downstream read-data buffer.
package ahb_lite_pkg;

  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

endpackage

// File: rtl/ahb_lite_hrdata_read_buffer_if.sv
// Bus-side capture signals plus the consumer valid/ready handshake of the
// HRDATA read buffer.
interface ahb_lite_hrdata_read_buffer_if
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH = AHB_DATA_WIDTH
) ();

  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  hrdata_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;

  modport slave (
    input  HREADY, HRDATA, hrdata_ready, rd_ready,
    output rd_valid, rd_data
  );

  modport master (
    output HREADY, HRDATA, hrdata_ready, rd_ready,
    input  rd_valid, rd_data
  );

endinterface

// File: rtl/ahb_lite_hrdata_read_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word, wrapping pointers
// and a separate occupancy counter.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [PTR_W:0]        count_q;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign rd_valid   = (count_q != '0);
  assign count      = count_q;

  // NOTE: storage carries no reset; only pointers, count and the head register
  // define visible state, so the array maps onto plain RAM/flops without reset.
  always_ff @(posedge HCLK) begin
    if (wr_en && !clear) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr_nxt;

      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Head register: the word behind the head, or the incoming word when
      // the FIFO holds at most the entry being popped.
      if (rd_en) begin
        if (wr_en && count_q == (PTR_W+1)'(1)) rd_data <= wr_data;
        else                                   rd_data <= mem[rd_ptr_nxt];
      end else if (wr_en && count_q == '0) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_hrdata_read_buffer.sv
// Passive HRDATA capture: qualifies the master's read strobe into one push per
// completed read data phase and queues the words for an in-order consumer.
module ahb_lite_hrdata_read_buffer
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH = AHB_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  ahb_lite_hrdata_read_buffer_if.slave  bus,
  input  logic                          clear,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);

  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  hready_q;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  full;
  logic                  fifo_rd_valid;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q <= '0;
      hready_q <= 1'b0;
    end else begin
      hready_q <= bus.HREADY;
      if (bus.HREADY) hrdata_q <= bus.HRDATA;
    end
  end

  // hrdata_ready stays high through wait states; hready_q limits it to the
  // single cycle following the completed data phase.
  assign push  = bus.hrdata_ready & hready_q;
  assign pop   = fifo_rd_valid & bus.rd_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 overflow <= 1'b0;
    else if (clear)               overflow <= 1'b0;
    else if (push & full & ~pop)  overflow <= 1'b1;
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_data  (hrdata_q),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (full),
    .count    (count)
  );

  assign bus.rd_valid = fifo_rd_valid;
  assign bus.rd_data  = fifo_rd_data;

endmodule

// File: tb/tb_ahb_lite_hrdata_read_buffer.sv
// Directed self-checking bench for the HRDATA read buffer.
module tb_ahb_lite_hrdata_read_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b1;
  logic       clear   = 1'b0;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ahb_lite_hrdata_read_buffer_if #(.DATA_WIDTH(DW)) bus ();

  ahb_lite_hrdata_read_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .clear    (clear),
    .count    (count),
    .overflow (overflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Read data phases ending on consecutive edges; master strobe follows one edge later.
  task automatic do_reads(input logic [31:0] first, input int n);
    bus.HRDATA = first;
    step();
    bus.hrdata_ready = 1'b1;
    for (int i = 1; i < n; i++) begin
      bus.HRDATA = first + 32'(i);
      step();
    end
    bus.HRDATA = '0;
    step();
    bus.hrdata_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.rd_data), 64'(exp));
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.HREADY       = 1'b1;
    bus.HRDATA       = '0;
    bus.hrdata_ready = 1'b0;
    bus.rd_ready     = 1'b0;

    // Reset values
    #1 HRESETn = 1'b0;
    #1;
    check("rst_valid",    64'(bus.rd_valid), 64'd0);
    check("rst_data",     64'(bus.rd_data),  64'd0);
    check("rst_count",    64'(count),        64'd0);
    check("rst_overflow", 64'(overflow),     64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single read: no bypass, word appears after E+1
    bus.HRDATA = 32'hDEAD_BEEF;
    step();
    bus.hrdata_ready = 1'b1;
    bus.HRDATA       = '0;
    check("single_at_E_count", 64'(count), 64'd0);
    check("single_at_E_valid", 64'(bus.rd_valid), 64'd0);
    step();
    bus.hrdata_ready = 1'b0;
    check("single_valid", 64'(bus.rd_valid), 64'd1);
    check("single_data",  64'(bus.rd_data),  64'hDEAD_BEEF);
    check("single_count", 64'(count),        64'd1);
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    check("single_pop_count", 64'(count),        64'd0);
    check("single_pop_valid", 64'(bus.rd_valid), 64'd0);

    // Wait states: one push despite hrdata_ready held high
    bus.HRDATA = 32'hA1A1_0001;
    step();
    bus.hrdata_ready = 1'b1;
    bus.HREADY       = 1'b0;
    bus.HRDATA       = 32'h0BAD_0BAD;
    step();
    step();
    step();
    check("ws_low_count", 64'(count), 64'd1);
    bus.HREADY = 1'b1;
    step();
    bus.hrdata_ready = 1'b0;
    bus.HRDATA       = '0;
    check("ws_release_count", 64'(count), 64'd1);
    step();
    check("ws_after_count", 64'(count), 64'd1);
    pop_expect("ws_word", 32'hA1A1_0001);

    // Back-to-back reads then overflow without pop
    do_reads(32'd1, 4);
    check("b2b_count", 64'(count), 64'd4);
    check("b2b_overflow", 64'(overflow), 64'd0);
    do_reads(32'd5, 1);
    check("ovf_flag",  64'(overflow), 64'd1);
    check("ovf_count", 64'(count),    64'd4);
    pop_expect("ovf_w1", 32'd1);
    pop_expect("ovf_w2", 32'd2);
    pop_expect("ovf_w3", 32'd3);
    pop_expect("ovf_w4", 32'd4);
    check("ovf_sticky",      64'(overflow), 64'd1);
    check("ovf_drain_count", 64'(count),    64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_ovf", 64'(overflow), 64'd0);

    // Push while full with a simultaneous pop
    do_reads(32'd1, 4);
    bus.HRDATA = 32'd5;
    step();
    bus.hrdata_ready = 1'b1;
    bus.rd_ready     = 1'b1;
    bus.HRDATA       = '0;
    step();
    bus.hrdata_ready = 1'b0;
    bus.rd_ready     = 1'b0;
    check("fullpop_overflow", 64'(overflow), 64'd0);
    check("fullpop_count",    64'(count),    64'd4);
    pop_expect("fullpop_w2", 32'd2);
    pop_expect("fullpop_w3", 32'd3);
    pop_expect("fullpop_w4", 32'd4);
    pop_expect("fullpop_w5", 32'd5);

    // Clear beats simultaneous push and pop
    do_reads(32'h10, 2);
    check("clr_pre_count", 64'(count), 64'd2);
    bus.HRDATA = 32'h20;
    step();
    bus.hrdata_ready = 1'b1;
    bus.rd_ready     = 1'b1;
    clear            = 1'b1;
    step();
    clear            = 1'b0;
    bus.hrdata_ready = 1'b0;
    bus.rd_ready     = 1'b0;
    check("clr_count",    64'(count),        64'd0);
    check("clr_valid",    64'(bus.rd_valid), 64'd0);
    check("clr_overflow", 64'(overflow),     64'd0);
    check("clr_data",     64'(bus.rd_data),  64'd0);
    step();
    check("clr_lost_count", 64'(count), 64'd0);

    // Sustained throughput with rd_ready held high
    bus.rd_ready = 1'b1;
    do_reads(32'h50, 3);
    check("tput_count", 64'(count),       64'd1);
    check("tput_data",  64'(bus.rd_data), 64'h52);
    step();
    bus.rd_ready = 1'b0;
    check("tput_drain", 64'(count), 64'd0);

    // Asynchronous reset mid-stream
    do_reads(32'h30, 4);
    do_reads(32'h34, 1);
    pop_expect("mid_w30", 32'h30);
    check("mid_pre_count",    64'(count),    64'd3);
    check("mid_pre_overflow", 64'(overflow), 64'd1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_valid",    64'(bus.rd_valid), 64'd0);
    check("mid_rst_data",     64'(bus.rd_data),  64'd0);
    check("mid_rst_count",    64'(count),        64'd0);
    check("mid_rst_overflow", 64'(overflow),     64'd0);
    check("mid_rst_hrdata_q", 64'(dut.hrdata_q), 64'd0);
    check("mid_rst_hready_q", 64'(dut.hready_q), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    do_reads(32'h40, 1);
    check("resume_count", 64'(count), 64'd1);
    pop_expect("resume_word", 32'h40);
    check("resume_drain", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_hrdata_read_buffer.md
# ahb_lite_hrdata_read_buffer

Downstream companion of the AHB-Lite master read/write interface. It captures HRDATA at the end of each read data phase and queues the captured word in a small FIFO, using the master's registered `hrdata_ready` strobe as its write enable. It presents the words to the consuming logic in request order through a valid/ready handshake. The block is passive on the bus and never drives any AHB signal.

## Interface
- `DATA_WIDTH`, default 32: width of HRDATA and of the read-data path.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥ 2.
- `HCLK`  in  1: bus clock. The only clock in the block.
- `HRESETn`  in  1: reset, asynchronous assert, active-low.
- `HREADY`  in  1: AHB-Lite transfer-done signal, shared with the master interface.
- `HRDATA`  in  DATA_WIDTH: AHB read data bus.
- `hrdata_ready`  in  1: strobe from the master interface, registered on HREADY. Marks that the last completed data phase was a read.
- `clear`  in  1: synchronous flush of the FIFO and the status flags.
- `rd_valid`  out  1: the head entry is available.
- `rd_data`  out  DATA_WIDTH: the head entry, show-ahead.
- `rd_ready`  in  1: the consumer accepts the head entry.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `overflow`  out  1: sticky flag, set when a captured word is dropped.

## Operation
- Capture register `hrdata_q`: loads HRDATA on every HCLK edge where HREADY=1 and holds otherwise.
- Edge flag `hready_q`: holds HREADY as sampled on the previous edge.
- Push condition: `push = hrdata_ready & hready_q`.
  - While HREADY is low, `hrdata_ready` stays high. `hready_q` suppresses the duplicate pushes this would otherwise cause.
  - The pushed word is the `hrdata_q` value from before the edge.
- Pop condition: `pop = rd_valid & rd_ready`.
- FIFO ordering: pointers of width $clog2(DEPTH) that wrap naturally, plus a separate occupancy counter.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
  - Without a pop, the word is discarded, `overflow` is set to 1 and FIFO contents are unchanged.
- Push and pop on a non-empty, non-full FIFO: both take effect and `count` is unchanged.
- Push while empty: there is no bypass. `rd_valid` rises on the edge after the push.
- Pop while empty: impossible by construction, because `rd_valid` is 0.
- `clear`: on the next edge the pointers and `count` go to 0, `rd_valid` goes to 0 and `overflow` goes to 0. `clear` beats a simultaneous push or pop, and the pushed word is lost without setting `overflow`.
- `overflow` stays set until `clear` or reset.
- Asynchronous reset mid-operation: all state returns to reset values immediately and any in-flight words are lost.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `count`=0, `overflow`=0, `hrdata_q`=0, `hready_q`=0.
- Latency, with read data phase ending at edge E (HREADY=1):
  - `hrdata_q` loads at E.
  - The master raises `hrdata_ready` at E.
  - The push occurs at E+1.
  - `rd_valid` and `rd_data` become valid after E+1, two edges after the data phase ends.
- Throughput: one push per cycle for back-to-back single-cycle reads. Sustained throughput with `rd_ready` held at 1 is also one word per cycle.
- `rd_data` is registered from the head entry. It changes only after a pop, after a push into an empty FIFO, or after `clear`.

## Structure
- Package `ahb_lite_pkg` holds:
  - the HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10);
  - the HSIZE encodings;
  - the `AHB_DATA_WIDTH`=32 constant, shared with the master interface.
- Sub-module `sync_fifo` (DATA_WIDTH, DEPTH) implements storage, pointers, `count` and full/empty.
- The top level contains `hrdata_q`, `hready_q`, the push qualification and `overflow`.

## Test plan
- Single read: drive HRDATA=32'hDEAD_BEEF with HREADY=1 at E and `hrdata_ready` high for one cycle from E. Required: `rd_valid` high after E+1, `rd_data`=32'hDEAD_BEEF, `count`=1. Then `rd_ready`=1 for one cycle → `count`=0 and `rd_valid`=0.
- Wait states: hold HREADY low for 3 cycles after E with `hrdata_ready` held high, then one cycle with HREADY=1. Required: exactly one entry is pushed and `count`=1.
- Back-to-back reads: 4 reads with HRDATA 1,2,3,4, `rd_ready`=0. Required: `count`=4, and the words pop in order 1,2,3,4.
- Overflow: with DEPTH=4 and the FIFO full, apply a 5th push with HRDATA=5 and `rd_ready`=0. Required: `overflow`=1, `count`=4, contents 1-4 intact. Repeat with `rd_ready`=1 on the same cycle: `overflow` stays 0, and the sequence reads 2,3,4,5.
- Clear and push collision: with 2 entries stored, assert `clear` in the same cycle as a push. Required: `count`=0, `rd_valid`=0, `overflow`=0 on the next edge.
- Reset mid-stream: with 3 entries stored and `overflow`=1, pulse HRESETn low between edges. Required: all outputs go to 0 immediately, and normal capture resumes after release.
